// File: rtl/gcd_host_pkg.sv
// Shared types and widths for the GCD host initiator: FSM state encoding,
// operand/tag widths and the packed request FIFO entry width.
package gcd_host_pkg;

   localparam int GCD_W   = 8;
   localparam int TAG_W   = 4;
   localparam int ENTRY_W = 2 * GCD_W + TAG_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GO   = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } host_state_t;

endpackage

// File: rtl/gcd_host_fifo.sv
// Synchronous request FIFO with registered pointers; an extra pointer bit
// distinguishes full from empty. Push is refused when full, even alongside a pop.
module gcd_host_fifo
   import gcd_host_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = ENTRY_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; entries are only observable once written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/gcd_host.sv
// Go/done initiator for the GCD core: queues tagged operand pairs, runs one
// computation at a time and returns tagged results. Optional WAIT watchdog: GCD_HOST_TIMEOUT_EN.
module gcd_host
   import gcd_host_pkg::*;
#(
   parameter int DEPTH = 4
`ifdef GCD_HOST_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [GCD_W-1:0] req_a,
   input  logic [GCD_W-1:0] req_b,
   output logic             gcd_go,
   output logic [GCD_W-1:0] gcd_a,
   output logic [GCD_W-1:0] gcd_b,
   input  logic             gcd_done,
   input  logic [GCD_W-1:0] gcd_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [GCD_W-1:0] res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_err,
   output logic [1:0]       host_state
);

   host_state_t        state;
   logic [GCD_W-1:0]   op_a;
   logic [GCD_W-1:0]   op_b;
   logic [TAG_W-1:0]   op_tag;
   logic [TAG_W-1:0]   tag_cnt;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] head;
   logic [GCD_W-1:0]   head_a;
   logic [GCD_W-1:0]   head_b;
   logic [TAG_W-1:0]   head_tag;

`ifdef GCD_HOST_TIMEOUT_EN
   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES);
   logic [7:0] wd_cnt;
`endif

   assign req_ready  = !fifo_full;
   assign push       = req_valid && req_ready;
   assign pop        = (state == ST_IDLE) && !fifo_empty;
   assign {head_tag, head_a, head_b} = head;

   assign gcd_a      = op_a;
   assign gcd_b      = op_b;
   assign res_tag    = op_tag;
   assign host_state = state;

   gcd_host_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({tag_cnt, req_a, req_b}),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tag_cnt <= '0;
      else if (push) tag_cnt <= tag_cnt + 1'b1;
   end

   // Zero operands are answered directly (OR yields the nonzero one, or 0)
   // so the core is only launched on pairs it can actually reduce.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_a      <= '0;
         op_b      <= '0;
         op_tag    <= '0;
         gcd_go    <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_err   <= 1'b0;
`ifdef GCD_HOST_TIMEOUT_EN
         wd_cnt    <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  op_a   <= head_a;
                  op_b   <= head_b;
                  op_tag <= head_tag;
                  if ((head_a != '0) && (head_b != '0)) begin
                     gcd_go <= 1'b1;
                     state  <= ST_GO;
                  end else begin
                     res_data  <= head_a | head_b;
                     res_err   <= (head_a == '0) && (head_b == '0);
                     res_valid <= 1'b1;
                     state     <= ST_RESP;
                  end
               end
            end
            ST_GO: begin
               gcd_go <= 1'b0;
               state  <= ST_WAIT;
`ifdef GCD_HOST_TIMEOUT_EN
               wd_cnt <= '0;
`endif
            end
            ST_WAIT: begin
               if (gcd_done) begin
                  res_data  <= gcd_out;
                  res_err   <= 1'b0;
                  res_valid <= 1'b1;
                  state     <= ST_RESP;
               end
`ifdef GCD_HOST_TIMEOUT_EN
               else begin
                  wd_cnt <= wd_cnt + 8'd1;
                  if ((wd_cnt + 8'd1) == WD_LIMIT) begin
                     res_data  <= '0;
                     res_err   <= 1'b1;
                     res_valid <= 1'b1;
                     state     <= ST_RESP;
                  end
               end
`endif
            end
            ST_RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_host.sv
// Self-checking bench for gcd_host: directed steps plus randomized pairs,
// checked against a queue-based reference model and a behavioural GCD core.
module tb_gcd_host;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic       gcd_go;
   logic [7:0] gcd_a;
   logic [7:0] gcd_b;
   logic       gcd_done;
   logic [7:0] gcd_out;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic [3:0] res_tag;
   logic       res_err;
   logic [1:0] host_state;

   typedef struct {
      logic [7:0] data;
      logic [3:0] tag;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   model_tag = 0;
   int   results_seen = 0;
   int   go_count = 0;
   int   stab_viol = 0;
   int   core_lat = 4;
   bit   core_stall = 0;
   bit   core_busy = 0;
   int   core_cnt = 0;
   logic [7:0] cap_a = 0;
   logic [7:0] cap_b = 0;

   gcd_host #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .gcd_go     (gcd_go),
      .gcd_a      (gcd_a),
      .gcd_b      (gcd_b),
      .gcd_done   (gcd_done),
      .gcd_out    (gcd_out),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_tag    (res_tag),
      .res_err    (res_err),
      .host_state (host_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] refGcd(input logic [7:0] a, input logic [7:0] b);
      int x = a;
      int y = b;
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return 8'(x);
   endfunction

   function automatic logic [7:0] coreGcd(input logic [7:0] a, input logic [7:0] b);
      int x = a;
      int y = b;
      while (x != y) begin
         if (x > y) x = x - y;
         else y = y - x;
      end
      return 8'(x);
   endfunction

   // Behavioural GCD core: launches on gcd_go, answers after core_lat cycles unless stalled.
   always @(negedge clk) begin
      if (rst) begin
         core_busy = 0;
         gcd_done  = 1'b0;
         core_cnt  = 0;
      end else begin
         gcd_done = 1'b0;
         if (gcd_go) begin
            go_count++;
            core_busy = 1;
            cap_a     = gcd_a;
            cap_b     = gcd_b;
            core_cnt  = core_lat;
         end else if (core_busy) begin
            if (gcd_a !== cap_a || gcd_b !== cap_b) stab_viol++;
            if (!core_stall) begin
               if (core_cnt <= 1) begin
                  gcd_done  = 1'b1;
                  gcd_out   = coreGcd(cap_a, cap_b);
                  core_busy = 0;
               end else begin
                  core_cnt--;
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
      end
   endtask

   task automatic modelPush(input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e.tag = 4'(model_tag);
      if (a != 0 && b != 0) begin
         e.data = refGcd(a, b);
         e.err  = 1'b0;
      end else if (a == 0 && b == 0) begin
         e.data = 8'd0;
         e.err  = 1'b1;
      end else begin
         e.data = (a == 0) ? b : a;
         e.err  = 1'b0;
      end
      exp_q.push_back(e);
      model_tag = (model_tag + 1) % 16;
   endtask

   task automatic checkResult();
      exp_t e;
      results_seen++;
      checkOutput("result_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("res_data", res_data, e.data);
         checkOutput("res_tag", res_tag, e.tag);
         checkOutput("res_err", res_err, e.err);
      end
   endtask

   // Called at a falling edge: records handshakes that complete on the next rising edge.
   task automatic stepCycle(output bit pushed, output bit got_res);
      pushed  = req_valid && req_ready;
      got_res = res_valid && res_ready;
      if (pushed) modelPush(req_a, req_b);
      if (got_res) checkResult();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
      bit p = 0;
      bit r;
      int n = 0;
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      while (!p && n < 60) begin
         stepCycle(p, r);
         n++;
      end
      req_valid = 1'b0;
      if (!p) checkOutput("push_timeout", 32'(p), 1);
   endtask

   task automatic drainResults(input int bound);
      bit p;
      bit r;
      int n = 0;
      res_ready = 1'b1;
      while (exp_q.size() > 0 && n < bound) begin
         stepCycle(p, r);
         n++;
      end
      res_ready = 1'b0;
      checkOutput("drain_outstanding", exp_q.size(), 0);
   endtask

   task automatic waitState(input logic [1:0] st, input int bound);
      bit p;
      bit r;
      int n = 0;
      while (host_state !== st && n < bound) begin
         stepCycle(p, r);
         n++;
      end
      checkOutput("wait_state", host_state, st);
   endtask

   task automatic doReset();
      req_valid = 1'b0;
      res_ready = 1'b0;
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      model_tag = 0;
   endtask

   task automatic checkResetValues(input string pfx);
      checkOutput({pfx, "_req_ready"}, req_ready, 1);
      checkOutput({pfx, "_gcd_go"}, gcd_go, 0);
      checkOutput({pfx, "_gcd_a"}, gcd_a, 0);
      checkOutput({pfx, "_gcd_b"}, gcd_b, 0);
      checkOutput({pfx, "_res_valid"}, res_valid, 0);
      checkOutput({pfx, "_res_data"}, res_data, 0);
      checkOutput({pfx, "_res_tag"}, res_tag, 0);
      checkOutput({pfx, "_res_err"}, res_err, 0);
      checkOutput({pfx, "_host_state"}, host_state, 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      bit p;
      bit r;
      int go_before;
      int cnt;
      logic [7:0] ra;
      logic [7:0] rb;

      rst = 1'b1;
      req_valid = 1'b0;
      req_a = '0;
      req_b = '0;
      res_ready = 1'b0;
      gcd_done = 1'b0;
      gcd_out = '0;
      doReset();
      checkResetValues("reset");

      // (48,18): latency, single launch, stable operands, result 6 tag 0
      go_before = go_count;
      applyStimulus(8'd48, 8'd18);
      checkOutput("t1_pop_cycle_state", host_state, 0);
      checkOutput("t1_pop_cycle_go", gcd_go, 0);
      stepCycle(p, r);
      checkOutput("t1_go_pulse", gcd_go, 1);
      checkOutput("t1_go_state", host_state, 1);
      checkOutput("t1_gcd_a", gcd_a, 48);
      checkOutput("t1_gcd_b", gcd_b, 18);
      stepCycle(p, r);
      checkOutput("t1_wait_state", host_state, 2);
      checkOutput("t1_go_dropped", gcd_go, 0);
      drainResults(50);
      checkOutput("t1_go_count", go_count - go_before, 1);
      checkOutput("t1_stability", stab_viol, 0);

      // Zero-operand bypass: no launch, results 7/tag1 and 0/err
      go_before = go_count;
      applyStimulus(8'd0, 8'd7);
      stepCycle(p, r);
      checkOutput("t2_bypass_valid", res_valid, 1);
      checkOutput("t2_bypass_state", host_state, 3);
      applyStimulus(8'd0, 8'd0);
      drainResults(50);
      checkOutput("t2_no_go", go_count - go_before, 0);

      // Held result: res_ready low for 10 cycles with another request queued
      applyStimulus(8'd35, 8'd49);
      applyStimulus(8'd12, 8'd8);
      waitState(2'd3, 50);
      go_before = go_count;
      for (int i = 0; i < 10; i++) begin
         checkOutput("t4_hold_valid", res_valid, 1);
         checkOutput("t4_hold_data", res_data, exp_q[0].data);
         stepCycle(p, r);
      end
      checkOutput("t4_no_new_go", go_count - go_before, 0);
      drainResults(100);

      // FIFO full behind a stalled computation
      doReset();
      core_stall = 1;
      applyStimulus(8'd90, 8'd60);
      waitState(2'd2, 20);
      for (int i = 0; i < 4; i++) applyStimulus(8'(20 + 4 * i), 8'(6 + 2 * i));
      req_valid = 1'b1;
      req_a = 8'd77;
      req_b = 8'd33;
      for (int i = 0; i < 3; i++) begin
         checkOutput("t3_req_ready_low", req_ready, 0);
         stepCycle(p, r);
         checkOutput("t3_blocked_push", 32'(p), 0);
      end
      core_stall = 0;
      res_ready = 1'b1;
      cnt = 0;
      p = 0;
      while (!p && cnt < 50) begin
         stepCycle(p, r);
         cnt++;
      end
      req_valid = 1'b0;
      checkOutput("t3_fifth_accepted", 32'(p), 1);
      drainResults(200);

      // Randomized pairs with random core latency
      for (int batch = 0; batch < 6; batch++) begin
         core_lat = $urandom_range(1, 6);
         for (int k = 0; k < 3; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) ra = 8'd0;
            if ($urandom_range(0, 7) == 0) rb = 8'd0;
            applyStimulus(ra, rb);
         end
         drainResults(300);
      end

`ifdef GCD_HOST_TIMEOUT_EN
      // Watchdog: stalled core times out after exactly 255 WAIT cycles
      begin
         exp_t e;
         core_stall = 1;
         applyStimulus(8'd10, 8'd4);
         e = exp_q.pop_back();
         e.data = 8'd0;
         e.err = 1'b1;
         exp_q.push_back(e);
         waitState(2'd2, 20);
         cnt = 0;
         while (host_state === 2'd2 && cnt < 400) begin
            cnt++;
            stepCycle(p, r);
         end
         checkOutput("tmo_wait_cycles", cnt, 255);
         drainResults(20);
         core_stall = 0;
         applyStimulus(8'd21, 8'd14);
         drainResults(50);
      end
`endif

      // Reset during WAIT with two requests queued
      core_stall = 1;
      applyStimulus(8'd9, 8'd6);
      waitState(2'd2, 20);
      applyStimulus(8'd15, 8'd5);
      applyStimulus(8'd0, 8'd3);
      #2;
      rst = 1'b1;
      #1;
      checkResetValues("midrst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      model_tag = 0;
      core_stall = 0;
      go_before = go_count;
      cnt = results_seen;
      res_ready = 1'b1;
      for (int i = 0; i < 30; i++) stepCycle(p, r);
      res_ready = 1'b0;
      checkOutput("rst_no_result", results_seen - cnt, 0);
      checkOutput("rst_no_go", go_count - go_before, 0);
      applyStimulus(8'd100, 8'd75);
      drainResults(50);

      checkOutput("operand_stability", stab_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gcd_host.md
# gcd_host

Initiator for the GCD core's go/done handshake. It accepts operand pairs from an upstream valid/ready stream and buffers them in a small FIFO. It launches one GCD computation at a time, holding the operands stable until `done`, and returns each result with a sequence tag on a downstream valid/ready stream. It sits between the system-side request source and the existing GCD controller/datapath top.

## Interface
- `DEPTH`, 4: request FIFO entries (power of two, ≥2).
- `TIMEOUT_CYCLES`, 255: watchdog limit in WAIT (used only with `GCD_HOST_TIMEOUT_EN`).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: upstream operand pair valid.
- `req_ready` out 1: `!fifo_full`.
- `req_a`, `req_b` in 8: operands.
- `gcd_go` out 1: one-cycle launch pulse to the GCD core.
- `gcd_a`, `gcd_b` out 8: operands to the core's `data_in1`/`data_in2`.
- `gcd_done` in 1: completion from the core.
- `gcd_out` in 8: result from the core.
- `res_valid` out 1: result available.
- `res_ready` in 1: downstream accepts.
- `res_data` out 8: GCD result.
- `res_tag` out 4: sequence tag of the originating request.
- `res_err` out 1: error flag (both operands zero, or timeout).
- `host_state` out 2: current FSM state, for debug.

## Operation
- Push: `req_valid && req_ready`. The pair and the current tag are written to the FIFO, then the tag increments, wrapping 15→0. When the FIFO is full, push is blocked even if a pop happens in the same cycle.
- FSM states, encoding IDLE=0, GO=1, WAIT=2, RESP=3:
  - IDLE: if the FIFO is not empty, pop the head into `op_a`/`op_b`/`op_tag`.
    - If both operands are nonzero, go to GO.
    - If exactly one operand is zero, load `res_data` with the nonzero operand, set `res_err=0`, go to RESP.
    - If both are zero, load `res_data=0`, set `res_err=1`, go to RESP.
    - The zero-operand cases never launch the core.
  - GO: `gcd_go=1` for exactly this cycle, then go to WAIT.
  - WAIT: on `gcd_done=1`, capture `gcd_out` into `res_data`, set `res_err=0`, go to RESP.
  - RESP: `res_valid=1`, outputs held stable. On `res_ready`, go to IDLE.
- `gcd_a`/`gcd_b` always drive `op_a`/`op_b`. They change only on a pop, so they are stable from GO through WAIT.
- `gcd_done` is ignored in any state other than WAIT.
- Only one computation is ever outstanding.

## Timing
- Reset values: `req_ready=1`, `gcd_go=0`, `gcd_a=gcd_b=0`, `res_valid=0`, `res_data=0`, `res_tag=0`, `res_err=0`, `host_state=IDLE`, FIFO empty, tag counter 0.
- Reset is asynchronous. Asserting it mid-operation, including during WAIT, clears everything immediately, and `gcd_go` drops in the same cycle. Queued requests are discarded.
- Latency, request accepted at cycle 0 into an empty FIFO with the FSM in IDLE:
  - pop at cycle 1;
  - `gcd_go` high at cycle 2;
  - WAIT from cycle 3.
- `gcd_done` sampled at cycle N gives `res_valid` at N+1.
- Zero-operand bypass: `res_valid` at cycle 2.
- After a RESP handshake, the next pop can happen in the following cycle; GO follows one cycle after that pop.

## Configuration
- `GCD_HOST_TIMEOUT_EN` defined:
  - An 8-bit watchdog counter clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `gcd_done`, the FSM goes to RESP with `res_data=0` and `res_err=1`.
  - `gcd_done` in the same cycle as the limit wins, giving a normal result.
- `GCD_HOST_TIMEOUT_EN` undefined: WAIT is unbounded, and there is no counter or parameter logic.

## Structure
- `gcd_host_pkg` holds:
  - the state enum and its 2-bit encoding;
  - `GCD_W=8` and `TAG_W=4`;
  - the FIFO entry width, `2*GCD_W+TAG_W`.
- One sub-module, `gcd_host_fifo`: a synchronous FIFO with registered pointers, `full`/`empty` flags, and same-cycle push and pop when not full.
- The FSM, operand registers, tag counter and watchdog live in `gcd_host`.

## Test plan
- Push (48,18) with `res_ready=1` and a core model → exactly one `gcd_go` pulse; `gcd_a=48` and `gcd_b=18` are stable until `done`; result `res_data=6`, `res_tag=0`, `res_err=0`.
- Push (0,7) then (0,0) → no `gcd_go`. Results in order: (7, tag 0, err 0) then (0, tag 1, err 1).
- Push 5 pairs back-to-back while the core is stalled → `req_ready` drops after 4 are accepted. The 5th is accepted after the first pop. Results come back in order with tags 0–4.
- Hold `res_ready=0` for 10 cycles after a result → `res_valid` and `res_data` are held, and no new `gcd_go` is issued.
- With `GCD_HOST_TIMEOUT_EN` and `gcd_done` tied low → `res_err=1` and `res_data=0` after 255 WAIT cycles, then the next request proceeds.
- Assert `rst` during WAIT with 2 requests queued → all outputs return to reset values immediately, and no result is emitted after release.
